// File: rtl/md_unit_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; md_unit is the slave.
interface md_unit_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, md_op, A, B, input busy, md_stall, HI, LO);
   modport slave  (input start, md_op, A, B, output busy, md_stall, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Iterative-latency multiply/divide unit feeding HI/LO; results commit a fixed number of cycles after start.
// Optional MADD/MADDU accumulate ops are enabled by defining MD_MADD_EN.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);

`ifdef MD_MADD_EN
   localparam logic MADD_EN = 1'b1;
`else
   localparam logic MADD_EN = 1'b0;
`endif

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      tmp_hi_q, tmp_hi_d;
   logic [31:0]      tmp_lo_q, tmp_lo_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             skip_q, skip_d;

   // Even opcodes are the signed variants for every multiply/divide op.
   logic is_signed;
   assign is_signed = ~md.md_op[0];

   // One shared 64-bit multiplier; operands are sign- or zero-extended.
   logic [63:0] mul_a, mul_b, prod;
   assign mul_a = is_signed ? {{32{md.A[31]}}, md.A} : {32'd0, md.A};
   assign mul_b = is_signed ? {{32{md.B[31]}}, md.B} : {32'd0, md.B};
   assign prod  = mul_a * mul_b;

   // Signed divide runs on magnitudes and fixes signs afterwards, which also
   // gives 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
   logic [31:0] b_safe, a_mag, b_mag, div_n, div_d, quo_u, rem_u, quo, rem;
   logic        q_neg;
   assign b_safe = (md.B == 32'd0) ? 32'd1 : md.B;
   assign a_mag  = md.A[31] ? (32'd0 - md.A) : md.A;
   assign b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
   assign div_n  = is_signed ? a_mag : md.A;
   assign div_d  = is_signed ? b_mag : b_safe;
   assign quo_u  = div_n / div_d;
   assign rem_u  = div_n % div_d;
   assign q_neg  = is_signed & (md.A[31] ^ b_safe[31]);
   assign quo    = q_neg ? (32'd0 - quo_u) : quo_u;
   assign rem    = (is_signed & md.A[31]) ? (32'd0 - rem_u) : rem_u;

   logic [63:0] acc;
   assign acc = {hi_q, lo_q} + prod;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      skip_d   = skip_q;
      case (state_q)
         S_IDLE: begin
            if (md.start) begin
               case (md.md_op)
                  OP_MULT, OP_MULTU: begin
                     {tmp_hi_d, tmp_lo_d} = prod;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     skip_d  = 1'b0;
                     state_d = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     tmp_hi_d = rem;
                     tmp_lo_d = quo;
                     cnt_d    = CNT_W'(DIV_CYCLES);
                     skip_d   = (md.B == 32'd0);
                     state_d  = S_BUSY;
                  end
                  OP_MTHI: hi_d = md.A;
                  OP_MTLO: lo_d = md.A;
                  OP_MADD, OP_MADDU: begin
                     if (MADD_EN) begin
                        {tmp_hi_d, tmp_lo_d} = acc;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                        skip_d  = 1'b0;
                        state_d = S_BUSY;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               if (!skip_q) begin
                  hi_d = tmp_hi_q;
                  lo_d = tmp_lo_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tmp_hi_q <= '0;
         tmp_lo_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         skip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmp_hi_q <= tmp_hi_d;
         tmp_lo_q <= tmp_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         skip_q   <= skip_d;
      end
   end

   logic is_md, is_madd;
   assign is_md   = ~md.md_op[2];
   assign is_madd = md.md_op[2] & md.md_op[1];

   assign md.busy     = (state_q == S_BUSY);
   assign md.md_stall = md.busy | (md.start & (is_md | (MADD_EN & is_madd)));
   assign md.HI       = hi_q;
   assign md.LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected commits, a negedge monitor checks them.
// Build with MD_MADD_EN defined to exercise the accumulate ops.
module tb_md_unit;
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   typedef struct {
      int          id;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          txn_id  = 0;
   logic [31:0] m_hi, m_lo;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_commit(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
      exp_t e;
      e.id = txn_id; e.prev_hi = m_hi; e.prev_lo = m_lo;
      e.hi = hi; e.lo = lo; e.cyc = cyc;
      sb.push_back(e);
      txn_id++;
      m_hi = hi;
      m_lo = lo;
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic exp_stall);
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
      #1 check("md_stall_at_start", {31'd0, bus.md_stall}, {31'd0, exp_stall});
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (!bus.busy) break;
      end
      check("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   // Monitor: counts busy cycles, holds HI/LO steady while busy, checks values at commit.
   int   busy_cnt  = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt  = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.busy) begin
            busy_cnt++;
            if (sb.size() > 0) begin
               check("hold_hi", bus.HI, sb[0].prev_hi);
               check("hold_lo", bus.LO, sb[0].prev_lo);
            end
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_commit: got HI=0x%08h LO=0x%08h, expected no commit", bus.HI, bus.LO);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("[TB] txn %0d commit HI=0x%08h LO=0x%08h busy_cycles=%0d", e.id, bus.HI, bus.LO, busy_cnt);
               check("commit_hi", bus.HI, e.hi);
               check("commit_lo", bus.LO, e.lo);
               check("busy_cycles", busy_cnt, e.cyc);
            end
            busy_cnt = 0;
         end
         prev_busy = bus.busy;
      end
   end

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.md_op = 3'd0; bus.A = '0; bus.B = '0;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_hi", bus.HI, 32'd0);
      check("reset_lo", bus.LO, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);

      // -2 * 3 = -6
      expect_commit(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      start_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
      wait_idle();

      expect_commit(32'h00000001, 32'hFFFFFFFE, 5);
      start_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1);
      wait_idle();

      // -7 / 2 = -3 rem -1
      expect_commit(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      start_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
      wait_idle();

      start_op(OP_MTHI, 32'h11, 32'd0, 1'b0);
      start_op(OP_MTLO, 32'h22, 32'd0, 1'b0);
      m_hi = 32'h11; m_lo = 32'h22;
      check("mt_hi", bus.HI, 32'h11);
      check("mt_lo", bus.LO, 32'h22);

      // Divide by zero keeps HI/LO
      expect_commit(32'h11, 32'h22, 10);
      start_op(OP_DIVU, 32'd7, 32'd0, 1'b1);
      wait_idle();

      start_op(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
      check("mthi_hi", bus.HI, 32'hDEADBEEF);
      check("mthi_busy", {31'd0, bus.busy}, 32'd0);
      start_op(OP_MTLO, 32'h12345678, 32'd0, 1'b0);
      check("mtlo_lo", bus.LO, 32'h12345678);
      check("mtlo_hi", bus.HI, 32'hDEADBEEF);
      check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
      m_hi = 32'hDEADBEEF; m_lo = 32'h12345678;

      // Signed overflow
      expect_commit(32'h0, 32'h80000000, 10);
      start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_idle();

      // 100 / 7 = 14 rem 2; MULT launched at t+3 must be ignored
      expect_commit(32'd2, 32'd14, 10);
      start_op(OP_DIV, 32'd100, 32'd7, 1'b1);
      repeat (2) @(posedge clk);
      start_op(OP_MULT, 32'd5, 32'd5, 1'b1);
      wait_idle();

      // Reset mid-divide discards the pending result
      start_op(OP_DIV, 32'd50, 32'd5, 1'b1);
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("abort_hi", bus.HI, 32'd0);
      check("abort_lo", bus.LO, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      check("no_late_hi", bus.HI, 32'd0);
      check("no_late_lo", bus.LO, 32'd0);
      check("no_late_busy", {31'd0, bus.busy}, 32'd0);

      start_op(OP_MTHI, 32'd0, 32'd0, 1'b0);
      start_op(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
      m_hi = 32'd0; m_lo = 32'hFFFFFFFF;
`ifdef MD_MADD_EN
      expect_commit(32'd1, 32'd0, 5);
      start_op(OP_MADDU, 32'd1, 32'd1, 1'b1);
      wait_idle();
      // {1,0} + (-1 * 2)
      expect_commit(32'd0, 32'hFFFFFFFE, 5);
      start_op(OP_MADD, 32'hFFFFFFFF, 32'd2, 1'b1);
      wait_idle();
`else
      start_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
      check("maddu_nop_busy", {31'd0, bus.busy}, 32'd0);
      start_op(OP_MADD, 32'hFFFFFFFF, 32'd2, 1'b0);
      repeat (6) @(negedge clk);
      #1;
      check("madd_nop_hi", bus.HI, 32'd0);
      check("madd_nop_lo", bus.LO, 32'hFFFFFFFF);
      check("madd_nop_busy", {31'd0, bus.busy}, 32'd0);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit that sits beside the execute-stage ALU.
- Consumes the forwarded rs/rt operands latched by the execute pipeline register.
- Produces HI/LO for the mfhi/mflo path into the memory-stage pipeline register.
- Iterative-latency model: a result commits to HI/LO a fixed number of cycles after start. Its busy/stall output feeds the hazard controller, which stalls decode.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: launch operation md_op this cycle
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
A  input  32  rs operand, already forwarded
B  input  32  rt operand, already forwarded
busy  output  1  registered; high while an operation is in flight
md_stall  output  1  combinational: busy | (start & md_op<=3, or md_op>=6 when enabled)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, counter=0, pending result discarded.
- Two states.
- IDLE (busy=0):
  - start & MULT/MULTU: compute the 64-bit product (signed or unsigned) into {tmp_hi, tmp_lo}; counter=MULT_CYCLES; go BUSY.
  - start & DIV/DIVU: tmp_lo=quotient, tmp_hi=remainder (signed truncates toward zero, remainder takes the dividend's sign); counter=DIV_CYCLES; go BUSY.
  - start & MTHI: HI<=A on the same edge; no busy. MTLO: LO<=A likewise.
- BUSY (busy=1): counter decrements each edge. On the edge where counter==1: HI<=tmp_hi, LO<=tmp_lo, busy<=0, go IDLE.
- Latency: start sampled at edge t; busy high for cycles t+1..t+N; HI/LO show the new value from edge t+N; busy low after edge t+N (N = MULT_CYCLES or DIV_CYCLES).
- start while busy: ignored entirely; HI/LO and counter unaffected. The hazard controller must stall via md_stall.
- Divide by zero (B==0): busy sequence runs normally; HI/LO keep their previous values at commit.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO are never modified except at commit, MTHI/MTLO, or reset.
- md_stall lets decode stall any md/mf/mt instruction while busy, or in the start cycle.
- md_op values 6/7 with MD_MADD_EN undefined: treated as no-op (no busy, no write).

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - MADD: {HI,LO} + signed(A*B), 64-bit wrap.
  - MADDU: {HI,LO} + unsigned(A*B).
  - Both take MULT_CYCLES; the accumulate base is HI/LO sampled at start; md_stall covers op 6/7.
- Undefined: ops 6/7 are no-ops and md_stall ignores them.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=3 -> busy=1 for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after edge t+5; busy=0.
- MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles.
- DIVU A=7, B=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- MTHI A=0xDEADBEEF, then MTLO A=0x12345678 on consecutive cycles -> HI/LO updated on each edge; busy never asserted.
- DIV started, then a second start with MULT at cycle t+3 -> ignored; DIV result commits at t+10. Async reset asserted at t+5 -> HI=LO=0, busy=0 immediately, with no later commit.
- MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and busy=0.
